// File: rtl/cyt_rdma_hls_deadlock_detector_if.sv
// rtl/cyt_rdma_hls_deadlock_detector_if.sv - report word valid/ready bus for the deadlock detector
interface cyt_rdma_hls_deadlock_detector_if;
    logic        report_valid;
    logic        report_ready;
    logic [31:0] report_data;

    modport master (
        output report_valid,
        output report_data,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_data,
        output report_ready
    );
endinterface

// File: rtl/cyt_rdma_hls_deadlock_detector.sv
// rtl/cyt_rdma_hls_deadlock_detector.sv - qualifies persistent monitor block patterns into a sticky deadlock report
module cyt_rdma_hls_deadlock_detector #(
    parameter int NUM_MON   = 8,
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_MON-1:0]  mon_block,
    input  logic                clear,
    output logic                deadlock_detected,
    output logic [3:0]          deadlock_idx,
    output logic [CNT_W-1:0]    blocked_cycles,
    cyt_rdma_hls_deadlock_detector_if.master rpt
);
    typedef enum logic [1:0] {S_IDLE, S_WATCH, S_REPORT, S_HOLD} state_t;

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    state_t             state_q, state_d;
    logic [NUM_MON-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MON-1:0] lat_q, lat_d;
    logic [3:0]         idx_q, idx_d;
    logic               det_q, det_d;
    logic [15:0]        lat_ext;
    logic [CNT_W-1:0]   cnt_inc;

    // Lowest set bit wins: scanning downward lets the lowest index overwrite last.
    function automatic logic [3:0] low_idx(input logic [NUM_MON-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // State and datapath registers; reset returns everything to the idle, empty report.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            prev_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            det_q   <= det_d;
        end
    end

    // Next-state: persistence counting while watching, report handshake, clear overrides all.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        det_d   = det_q;
        cnt_inc = cnt_q + 1'b1;

        if (state_q != S_REPORT && state_q != S_HOLD) begin
            prev_d = mon_block;
        end

        case (state_q)
            S_IDLE: begin
                if (mon_block != '0) begin
                    state_d = S_WATCH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            S_WATCH: begin
                if (mon_block == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (mon_block != prev_q) begin
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == THR) begin
                        state_d = S_REPORT;
                        lat_d   = mon_block;
                        idx_d   = low_idx(mon_block);
                        det_d   = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                if (rpt.report_ready) state_d = S_HOLD;
            end
            default: ;
        endcase

        // A clear drops any in-flight qualification or handshake and re-arms.
        if (clear) begin
            state_d = S_IDLE;
            prev_d  = '0;
            cnt_d   = '0;
            lat_d   = '0;
            idx_d   = '0;
            det_d   = 1'b0;
        end
    end

    // Report word assembly: latched vector zero-extended to 16 bits.
    always_comb begin
        lat_ext               = '0;
        lat_ext[NUM_MON-1:0]  = lat_q;
    end

    assign deadlock_detected = det_q;
    assign deadlock_idx      = idx_q;
    assign blocked_cycles    = cnt_q;
    assign rpt.report_valid  = (state_q == S_REPORT);
    assign rpt.report_data   = {8'hDE, 4'h0, idx_q, lat_ext};
endmodule

// File: tb/tb_cyt_rdma_hls_deadlock_detector.sv
// tb/tb_cyt_rdma_hls_deadlock_detector.sv - directed and randomized bench against a run-length reference model
module tb_cyt_rdma_hls_deadlock_detector;
    localparam int NUM_MON = 8;
    localparam int THR     = 4;
    localparam int CNT_W   = 16;

    logic             clock;
    logic             reset;
    logic [7:0]       mon_block;
    logic             clear;
    logic             deadlock_detected;
    logic [3:0]       deadlock_idx;
    logic [CNT_W-1:0] blocked_cycles;

    cyt_rdma_hls_deadlock_detector_if rif();

    cyt_rdma_hls_deadlock_detector #(
        .NUM_MON(NUM_MON), .THRESHOLD(THR), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mon_block(mon_block),
        .clear(clear),
        .deadlock_detected(deadlock_detected),
        .deadlock_idx(deadlock_idx),
        .blocked_cycles(blocked_cycles),
        .rpt(rif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: length of the current run of one identical non-zero vector,
    // plus the latched detection and whether its single report word is still owed.
    int         m_run;
    logic [7:0] m_last;
    logic       m_det;
    logic       m_pending;
    logic [7:0] m_lat;
    int         m_idx;
    int         m_delivered;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic [7:0] mb, input logic clr, input logic rdy, input logic rst);
        if (rst || clr) begin
            m_run = 0; m_last = 8'h00; m_det = 1'b0; m_pending = 1'b0; m_lat = 8'h00; m_idx = 0;
        end else if (!m_det) begin
            if (mb == 8'h00)                    m_run = 0;
            else if (m_run > 0 && mb == m_last) m_run = m_run + 1;
            else                                m_run = 1;
            m_last = mb;
            if (m_run == THR) begin
                m_det = 1'b1; m_pending = 1'b1; m_lat = mb;
                m_idx = 0;
                while (!mb[m_idx]) m_idx++;
            end
        end else if (m_pending && rdy) begin
            m_pending = 1'b0;
            m_delivered++;
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_data;
        exp_data = {8'hDE, 4'h0, 4'(m_idx), 8'h00, m_lat};
        check("deadlock_detected", 32'(deadlock_detected), 32'(m_det));
        check("deadlock_idx", 32'(deadlock_idx), 32'(m_idx));
        check("blocked_cycles", 32'(blocked_cycles), 32'(m_run));
        check("report_valid", 32'(rif.report_valid), 32'(m_pending));
        check("report_data", rif.report_data, exp_data);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, sample 1ns later.
    task automatic step(input logic [7:0] mb, input logic clr, input logic rdy, input logic rst);
        mon_block = mb; clear = clr; rif.report_ready = rdy; reset = rst;
        @(posedge clock);
        model_update(mb, clr, rdy, rst);
        #1;
        compare_all();
    endtask

    logic [7:0] cand [7];
    logic [7:0] cur;
    logic [31:0] held;

    initial begin
        m_delivered = 0;
        mon_block = 8'h00; clear = 1'b0; rif.report_ready = 1'b0; reset = 1'b1;
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("reset_det", 32'(deadlock_detected), 32'd0);
        check("reset_valid", 32'(rif.report_valid), 32'd0);
        check("reset_data", rif.report_data, 32'hDE00_0000);
        check("reset_cnt", 32'(blocked_cycles), 32'd0);

        // Persistent 8'h80 qualifies on the fourth edge; one-cycle report then HOLD.
        for (int i = 0; i < 4; i++) step(8'h80, 1'b0, 1'b1, 1'b0);
        check("t1_det", 32'(deadlock_detected), 32'd1);
        check("t1_idx", 32'(deadlock_idx), 32'd7);
        check("t1_data", rif.report_data, 32'hDE07_0080);
        check("t1_valid", 32'(rif.report_valid), 32'd1);
        step(8'h80, 1'b0, 1'b1, 1'b0);
        check("t1_hold_valid", 32'(rif.report_valid), 32'd0);
        check("t1_hold_det", 32'(deadlock_detected), 32'd1);
        step(8'h00, 1'b1, 1'b0, 1'b0);

        // Short run then zero: no detection, counter back to 0.
        for (int i = 0; i < 3; i++) step(8'h04, 1'b0, 1'b1, 1'b0);
        check("t2_cnt3", 32'(blocked_cycles), 32'd3);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("t2_det", 32'(deadlock_detected), 32'd0);
        check("t2_cnt", 32'(blocked_cycles), 32'd0);

        // Pattern change restarts the count.
        for (int i = 0; i < 3; i++) step(8'h06, 1'b0, 1'b1, 1'b0);
        step(8'h02, 1'b0, 1'b1, 1'b0);
        check("t3_restart", 32'(blocked_cycles), 32'd1);
        for (int i = 0; i < 3; i++) step(8'h02, 1'b0, 1'b0, 1'b0);
        check("t3_idx", 32'(deadlock_idx), 32'd1);
        check("t3_data", rif.report_data, 32'hDE01_0002);

        // Backpressure with toggling inputs: word held stable until accepted.
        held = rif.report_data;
        for (int i = 0; i < 10; i++) begin
            step((i % 2) ? 8'h55 : 8'h00, 1'b0, 1'b0, 1'b0);
            check("bp_valid", 32'(rif.report_valid), 32'd1);
            check("bp_stable", rif.report_data, held);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("bp_accept", 32'(rif.report_valid), 32'd0);
        step(8'h00, 1'b1, 1'b0, 1'b0);

        // Clear on the qualifying edge wins, then a fresh detection of 8'h01.
        for (int i = 0; i < 3; i++) step(8'h01, 1'b0, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b1, 1'b0);
        check("t5_det", 32'(deadlock_detected), 32'd0);
        check("t5_cnt", 32'(blocked_cycles), 32'd0);
        for (int i = 0; i < 4; i++) step(8'h01, 1'b0, 1'b0, 1'b0);
        check("t5_idx", 32'(deadlock_idx), 32'd0);
        check("t5_data", rif.report_data, 32'hDE00_0001);

        // Clear coincident with a report handshake drops the word.
        step(8'h01, 1'b1, 1'b1, 1'b0);
        check("clr_hs_valid", 32'(rif.report_valid), 32'd0);

        // Reset while in REPORT discards the word.
        for (int i = 0; i < 4; i++) step(8'h10, 1'b0, 1'b0, 1'b0);
        check("t6_valid", 32'(rif.report_valid), 32'd1);
        step(8'h10, 1'b0, 1'b1, 1'b1);
        check("t6_valid_rst", 32'(rif.report_valid), 32'd0);
        check("t6_data_rst", rif.report_data, 32'hDE00_0000);

        // Randomized runs of sticky vectors with random backpressure, clears and resets.
        cand[0] = 8'h00; cand[1] = 8'h80; cand[2] = 8'h04; cand[3] = 8'h06;
        cand[4] = 8'h02; cand[5] = 8'h01; cand[6] = 8'h00;
        cur = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                cand[6] = 8'($urandom);
                cur = cand[$urandom_range(0, 6)];
            end
            step(cur,
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 249) == 0));
        end
        check("rand_reports_seen", 32'(m_delivered > 5), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cyt_rdma_hls_deadlock_detector.md
# cyt_rdma_hls_deadlock_detector

Top-level deadlock detector for the cyt_rdma HLS kernel; sits directly downstream of the per-instance deadlock monitors (one `block` bit per monitored sub-pipeline, e.g. the rx loop monitor). It qualifies the raw per-monitor block flags by requiring an identical non-zero block pattern to persist for THRESHOLD consecutive cycles. On qualification it raises a sticky deadlock flag, identifies the lowest-indexed blocked monitor, and emits one 32-bit report word over a valid/ready handshake toward the debug/status path.

## Interface
- NUM_MON, 8, number of monitor inputs; legal range 1..16
- THRESHOLD, 1024, consecutive identical non-zero cycles required to declare deadlock; legal range 2..2^CNT_W-1
- CNT_W, 16, width of the persistence counter
- clock  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- mon_block  in  NUM_MON  block flag from each deadlock monitor; bit i from monitor idx i
- clear  in  1  single-cycle pulse; re-arms the detector
- deadlock_detected  out  1  sticky deadlock flag
- deadlock_idx  out  4  lowest set bit index of the latched block vector
- blocked_cycles  out  CNT_W  current persistence count
- report_valid  out  1  report word available
- report_ready  in  1  downstream accepts report
- report_data  out  32  {8'hDE, 4'h0, deadlock_idx, latched vector zero-extended to 16 bits}

## Operation
- States: IDLE, WATCH, REPORT, HOLD.
- Internal regs: prev_vec (NUM_MON), cnt (CNT_W), lat_vec (NUM_MON), idx (4).
- Every edge outside REPORT/HOLD: prev_vec <= mon_block.
- IDLE: mon_block == 0 -> stay, cnt <= 0. mon_block != 0 -> WATCH, cnt <= 1.
- WATCH: mon_block == 0 -> IDLE, cnt <= 0. mon_block != 0 and != prev_vec -> stay, cnt <= 1 (restart). mon_block == prev_vec -> cnt <= cnt+1; if cnt+1 == THRESHOLD -> REPORT, lat_vec <= mon_block, idx <= lowest set bit of mon_block, deadlock_detected <= 1.
- REPORT: report_valid = 1; report_data stable. report_valid & report_ready -> HOLD. mon_block ignored; cnt frozen.
- HOLD: deadlock_detected stays 1; report_valid = 0; mon_block ignored until clear.
- clear (any state): -> IDLE, cnt <= 0, deadlock_detected <= 0, lat_vec <= 0, idx <= 0, prev_vec <= 0. clear has priority over every transition incl. a same-cycle qualification and a same-cycle report handshake (word counts as not delivered only if clear arrives; handshake is dropped).
- cnt never exceeds THRESHOLD; no wrap.
- Bits of report_data[15:NUM_MON] are 0.

## Timing
- Reset values: deadlock_detected 0, deadlock_idx 0, blocked_cycles 0, report_valid 0, report_data 32'hDE00_0000, state IDLE.
- Qualification: identical non-zero vector sampled at edges e1..eTHRESHOLD -> deadlock_detected and report_valid high after eTHRESHOLD (no extra latency).
- report_valid held until handshake; report_data must not change while report_valid is high.
- One report word per detection; a new detection requires clear.
- reset mid-REPORT: report_valid drops after the reset edge, word lost by design.
- blocked_cycles is the registered cnt, visible the cycle after update.

## Test plan
- THRESHOLD=4: mon_block=8'h80 held 4 cycles, report_ready=1 -> deadlock_detected=1 after 4th edge, deadlock_idx=7, report_data=32'hDE07_0080, one-cycle report_valid, then HOLD.
- THRESHOLD=4: mon_block=8'h04 for 3 cycles, then 8'h00 -> deadlock_detected stays 0, blocked_cycles returns to 0.
- THRESHOLD=4: 8'h06 for 3 cycles then 8'h02 for 4 cycles -> counter restarts at 1 on change; detection after 7th edge, idx=1, report_data=32'hDE01_0002.
- Backpressure: report_ready=0 for 10 cycles after detection with mon_block toggling -> report_valid held, report_data unchanged; accepted on first ready cycle, then report_valid=0.
- clear asserted on the qualifying edge -> no detection, state IDLE, cnt 0; subsequent 4 cycles of 8'h01 -> detection with idx=0.
- reset asserted while in REPORT -> all outputs return to reset values next edge; no report issued.
